// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage in front of the IF/ID pipeline register. It holds
//   the PC, runs a req/done handshake with a variable-latency instruction
//   memory, and presents one fetched instruction plus its sequential PC
//   (fetch address + 2) until the IF/ID register takes it. Branch redirects
//   from later stages squash in-flight or buffered fetches. Fetching stops
//   once a HALT instruction has been accepted, and resumes only on a redirect.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous, active-low reset
//   en             in   1   IF/ID write enable; presented instruction taken
//   branch         in   1   one-cycle redirect pulse
//   branch_target  in   16  redirect address, sampled with branch
//   mem_req        out  1   memory request, held until mem_done
//   mem_addr       out  16  request address, stable while mem_req=1
//   mem_done       in   1   one-cycle pulse, mem_data valid
//   mem_data       in   16  instruction word
//   instruc        out  16  instruction to IF/ID (NOP_INSTR when not valid)
//   seq_PC         out  16  fetch address + 2 to IF/ID (0 when not valid)
//   valid          out  1   instruc/seq_PC carry a real instruction
//   halted         out  1   fetch stopped after a HALT
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h1800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        branch,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_done,
    input  logic [15:0] mem_data,
    output logic [15:0] instruc,
    output logic [15:0] seq_PC,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_WAIT,    // request outstanding
        S_HOLD,    // instruction buffered, waiting for en
        S_SQUASH,  // request outstanding but its data will be discarded
        S_HALTED   // HALT accepted, no requests
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;      // next fetch address
    logic [15:0] addr_q, addr_d;  // address of the outstanding request
    logic [15:0] ibuf_q, ibuf_d;  // buffered instruction
    logic        enter_wait;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of the order of statements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ibuf_q  <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ibuf_q  <= ibuf_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        ibuf_d     = ibuf_q;
        enter_wait = 1'b0;

        unique case (state_q)
            S_WAIT: begin
                if (branch) begin
                    pc_d = branch_target;
                    // Data arriving with the redirect is stale: drop it and
                    // start the redirected fetch straight away.
                    if (mem_done) enter_wait = 1'b1;
                    else          state_d    = S_SQUASH;
                end else if (mem_done) begin
                    ibuf_d  = mem_data;
                    pc_d    = addr_q + 16'd2;
                    state_d = S_HOLD;
                end
            end
            S_SQUASH: begin
                // Request stays stable; latest redirect wins.
                if (branch)   pc_d       = branch_target;
                if (mem_done) enter_wait = 1'b1;
            end
            S_HOLD: begin
                if (branch) begin
                    pc_d       = branch_target;
                    ibuf_d     = NOP_INSTR;
                    enter_wait = 1'b1;
                end else if (en) begin
                    if (ibuf_q[15:11] == HALT_OPC) state_d    = S_HALTED;
                    else                           enter_wait = 1'b1;
                end
            end
            S_HALTED: begin
                if (branch) begin
                    pc_d       = branch_target;
                    enter_wait = 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase

        // Every entry into WAIT (including re-entry) latches the new fetch
        // address, so a redirect issued this cycle is requested next cycle.
        if (enter_wait) begin
            state_d = S_WAIT;
            addr_d  = pc_d;
        end
    end

    // Reset leaves the state at WAIT; gating with rst keeps the request low
    // for as long as reset is asserted and lets it rise right after release.
    assign mem_req  = rst && ((state_q == S_WAIT) || (state_q == S_SQUASH));
    assign mem_addr = addr_q;
    assign valid    = (state_q == S_HOLD);
    assign halted   = (state_q == S_HALTED);
    assign instruc  = valid ? ibuf_q : NOP_INSTR;
    // In HOLD the PC has already advanced to the fetch address + 2, so it is
    // the sequential PC of the buffered instruction.
    assign seq_PC   = valid ? pc_q : 16'h0000;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Randomized bench for fetch_unit: a reactive memory with random latency,
//   random en/branch traffic and HALT words, checked each cycle against a
//   behavioural model of the fetch stage. Includes an asynchronous reset in
//   the middle of the run.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h1800;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        branch;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done;
    logic [15:0] mem_data;
    logic [15:0] instruc;
    logic [15:0] seq_PC;
    logic        valid;
    logic        halted;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .branch        (branch),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_done      (mem_done),
        .mem_data      (mem_data),
        .instruc       (instruc),
        .seq_PC        (seq_PC),
        .valid         (valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The stage either has a buffered instruction, is halted, or is fetching
    // (possibly a fetch whose result must be thrown away).
    bit          m_buf, m_halt, m_stale;
    logic [15:0] m_pc, m_addr, m_ibuf, m_seq;

    // memory model state
    int mem_cnt, mem_lat;

    // coverage-ish counters (informational only)
    int n_fetched, n_halts, n_wraps;

    function automatic bit exp_req();
        return rst && !m_buf && !m_halt;
    endfunction

    task automatic model_reset();
        m_buf = 0; m_halt = 0; m_stale = 0;
        m_pc = 16'h0000; m_addr = 16'h0000; m_ibuf = NOP; m_seq = 16'h0000;
        mem_cnt = 0; mem_done = 1'b0;
    endtask

    // One clock edge, using the inputs as they stood before the edge.
    task automatic model_step();
        if (m_halt) begin
            if (branch) begin
                m_halt = 0; m_pc = branch_target; m_addr = branch_target;
            end
        end else if (m_buf) begin
            if (branch) begin
                m_buf = 0; m_pc = branch_target; m_addr = branch_target;
            end else if (en) begin
                m_buf = 0;
                if (m_ibuf[15:11] == 5'b00000) begin
                    m_halt = 1; n_halts++;
                end else begin
                    m_addr = m_pc;
                end
            end
        end else begin
            if (branch) m_pc = branch_target;
            if (m_stale || branch) begin
                if (mem_done) begin
                    m_stale = 0; m_addr = m_pc;
                end else begin
                    m_stale = 1;
                end
            end else if (mem_done) begin
                m_buf  = 1;
                m_ibuf = mem_data;
                m_seq  = m_addr + 16'd2;
                m_pc   = m_seq;
                n_fetched++;
                if (m_addr == 16'hFFFE) n_wraps++;
            end
        end
    endtask

    task automatic compare(input string where);
        check({where, ".mem_req"},  {31'd0, mem_req}, {31'd0, exp_req()});
        check({where, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, m_addr});
        check({where, ".valid"},    {31'd0, valid},   {31'd0, (rst && m_buf)});
        check({where, ".instruc"},  {16'd0, instruc}, {16'd0, (rst && m_buf) ? m_ibuf : NOP});
        check({where, ".seq_PC"},   {16'd0, seq_PC},  {16'd0, (rst && m_buf) ? m_seq : 16'h0000});
        check({where, ".halted"},   {31'd0, halted},  {31'd0, (rst && m_halt)});
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] d;
        d = 16'($urandom);
        if ($urandom_range(0, 7) == 0) d[15:11] = 5'b00000;   // HALT
        else if (d[15:11] == 5'b00000) d[15:11] = 5'b00011;
        return d;
    endfunction

    function automatic logic [15:0] gen_target();
        case ($urandom_range(0, 4))
            0:       return 16'hFFFE;
            1:       return 16'h0100;
            2:       return 16'h0040;
            3:       return 16'hFFFC;
            default: return 16'($urandom);   // odd addresses pass through
        endcase
    endfunction

    // Drive inputs for the coming cycle (called just after a falling edge).
    // The memory answers in the lat-th cycle of an outstanding request.
    task automatic drive_next();
        if (exp_req()) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_done = 1'b1;
                mem_data = gen_word();
                mem_cnt  = 0;
                mem_lat  = $urandom_range(1, 3);
            end else begin
                mem_done = 1'b0;
                mem_data = 16'($urandom);
            end
        end else begin
            mem_cnt  = 0;
            mem_done = ($urandom_range(0, 15) == 0);   // stray pulses must be ignored
            mem_data = 16'($urandom);
        end
        en            = ($urandom_range(0, 9) < 7);
        branch        = !branch && ($urandom_range(0, 11) == 0);
        branch_target = gen_target();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; branch = 1'b0; branch_target = 16'h0000;
        mem_data = 16'h0000; mem_lat = 1;
        n_fetched = 0; n_halts = 0; n_wraps = 0;
        model_reset();
        #12;
        compare("reset");
        @(negedge clk);
        rst = 1'b1;
        drive_next();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare("run");

            if (cyc == 2000) begin
                // Asynchronous reset in the middle of a cycle.
                #2;
                rst = 1'b0;
                branch = 1'b0;
                model_reset();
                #1;
                compare("async_rst");
                @(posedge clk);
                @(negedge clk);
                compare("in_rst");
                rst = 1'b1;
                #1;
                compare("release");
            end
            drive_next();
        end

        $display("info: fetched %0d halts %0d wraps %0d", n_fetched, n_halts, n_wraps);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
